vc_rr_arbiter: RTL and testbench

- Downstream consumer of four 6-bit upstream FIFOs (FIFO_SIZE 8 each).
- Pops one word per cycle from the non-empty FIFOs in round-robin order.
- Decodes destination bits data[5:4] and pushes the word into one of four downstream FIFOs.
- Stalls all pops while any downstream FIFO reports almost-full, or while paused.

---
 rtl/vc_rr_arbiter_pkg.sv | 20 ++
 rtl/vc_rr_arbiter_rr_pick.sv | 28 ++
 rtl/vc_rr_arbiter.sv | 121 ++++++++++++
 tb/tb_vc_rr_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/vc_rr_arbiter_pkg.sv
// Shared constants, state encoding and one-hot helper for the VC round-robin arbiter.
package vc_rr_arbiter_pkg;

    localparam int DATA_W   = 6;
    localparam int NUM_Q    = 4;
    localparam int CNT_W    = 8;
    localparam int DEST_MSB = 5;
    localparam int DEST_LSB = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    function automatic logic [NUM_Q-1:0] idx_to_onehot(input logic [1:0] idx);
        idx_to_onehot = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/vc_rr_arbiter_rr_pick.sv
// Combinational 4-way round-robin selector: first requester after `last`, wrapping.
module vc_rr_arbiter_rr_pick
    import vc_rr_arbiter_pkg::*;
(
    input  logic [NUM_Q-1:0] req,
    input  logic [1:0]       last,
    output logic             gnt_valid,
    output logic [1:0]       gnt
);

    logic [1:0] idx_s;
    logic       hit_s;

    // Scan from farthest to nearest so the nearest requester after `last` wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt       = 2'd0;
        idx_s     = 2'd0;
        hit_s     = 1'b0;
        for (int k = 4; k >= 1; k--) begin
            idx_s     = last + 2'(k);
            hit_s     = req[idx_s];
            gnt_valid = gnt_valid | hit_s;
            gnt       = hit_s ? idx_s : gnt;
        end
    end

endmodule

// File: rtl/vc_rr_arbiter.sv
// Pops the upstream FIFOs round-robin and routes each word to the downstream FIFO
// named by its destination field, two cycles after the pop.
module vc_rr_arbiter
    import vc_rr_arbiter_pkg::*;
(
    input  logic                     clk,
    input  logic                     RESET_L,
    input  logic [NUM_Q-1:0]         fifo_empty,
    input  logic [NUM_Q*DATA_W-1:0]  data_in,
    input  logic [NUM_Q-1:0]         almost_full,
    input  logic                     pause,
    output logic [NUM_Q-1:0]         fifo_rd,
    output logic [NUM_Q-1:0]         push,
    output logic [DATA_W-1:0]        data_out,
    output logic                     active,
    output logic [NUM_Q*CNT_W-1:0]   cnt_dest
);

    arb_state_e                     state_q, state_d;
    logic [1:0]                     last_grant_q, last_grant_d;
    logic                           rd_pend_q, rd_pend_d;
    logic [1:0]                     rd_lane_q, rd_lane_d;
    logic [DATA_W-1:0]              data_out_q, data_out_d;
    logic [NUM_Q-1:0]               push_q, push_d;
    logic                           active_q, active_d;
    logic [NUM_Q-1:0][CNT_W-1:0]    cnt_q, cnt_d;

    logic [NUM_Q-1:0][DATA_W-1:0]   lane_s;
    logic [DATA_W-1:0]              word_s;
    logic [1:0]                     dest_s;
    logic                           gnt_valid_s;
    logic [1:0]                     gnt_s;
    logic                           issue_s;

    vc_rr_arbiter_rr_pick u_pick (
        .req       (~fifo_empty),
        .last      (last_grant_q),
        .gnt_valid (gnt_valid_s),
        .gnt       (gnt_s)
    );

    assign lane_s  = data_in;
    assign word_s  = lane_s[rd_lane_q];
    assign dest_s  = word_s[DEST_MSB:DEST_LSB];

    // Reset is folded in so no pop strobe escapes while the block is held in reset.
    assign issue_s = RESET_L & ~pause & ~(|almost_full) & gnt_valid_s;
    assign fifo_rd = issue_s ? idx_to_onehot(gnt_s) : {NUM_Q{1'b0}};

    assign push     = push_q;
    assign data_out = data_out_q;
    assign active   = active_q;
    assign cnt_dest = cnt_q;

    // Datapath: remember the pop, capture the word a cycle later and push it with its count.
    always_comb begin
        last_grant_d = last_grant_q;
        rd_pend_d    = issue_s;
        rd_lane_d    = rd_lane_q;
        data_out_d   = data_out_q;
        push_d       = {NUM_Q{1'b0}};
        cnt_d        = cnt_q;
        active_d     = issue_s | rd_pend_q;
        if (issue_s) begin
            last_grant_d = gnt_s;
            rd_lane_d    = gnt_s;
        end else begin
            last_grant_d = last_grant_q;
            rd_lane_d    = rd_lane_q;
        end
        if (rd_pend_q) begin
            data_out_d    = word_s;
            push_d        = idx_to_onehot(dest_s);
            cnt_d[dest_s] = cnt_q[dest_s] + CNT_W'(1);
        end else begin
            data_out_d = data_out_q;
            push_d     = {NUM_Q{1'b0}};
        end
    end

    // Pipeline occupancy tracking: DRAIN while only already-issued words remain.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (issue_s) state_d = RUN;
                else         state_d = IDLE;
            end
            RUN, DRAIN: begin
                if (issue_s)        state_d = RUN;
                else if (rd_pend_q) state_d = DRAIN;
                else                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; last_grant resets to 3 so the first grant lands on FIFO 0.
    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q      <= IDLE;
            last_grant_q <= 2'd3;
            rd_pend_q    <= 1'b0;
            rd_lane_q    <= 2'd0;
            data_out_q   <= {DATA_W{1'b0}};
            push_q       <= {NUM_Q{1'b0}};
            active_q     <= 1'b0;
            cnt_q        <= {(NUM_Q*CNT_W){1'b0}};
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rd_pend_q    <= rd_pend_d;
            rd_lane_q    <= rd_lane_d;
            data_out_q   <= data_out_d;
            push_q       <= push_d;
            active_q     <= active_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_vc_rr_arbiter.sv
// Scoreboard bench for vc_rr_arbiter: queue-based upstream FIFO model, grant model, push monitor.
module tb_vc_rr_arbiter;

    logic        clk = 1'b0;
    logic        RESET_L;
    logic [3:0]  fifo_empty;
    logic [23:0] data_in;
    logic [3:0]  almost_full;
    logic        pause;
    logic [3:0]  fifo_rd;
    logic [3:0]  push;
    logic [5:0]  data_out;
    logic        active;
    logic [31:0] cnt_dest;

    always #5 clk = ~clk;

    vc_rr_arbiter dut (
        .clk        (clk),
        .RESET_L    (RESET_L),
        .fifo_empty (fifo_empty),
        .data_in    (data_in),
        .almost_full(almost_full),
        .pause      (pause),
        .fifo_rd    (fifo_rd),
        .push       (push),
        .data_out   (data_out),
        .active     (active),
        .cnt_dest   (cnt_dest)
    );

    typedef struct packed {
        logic [5:0]  w;
        logic [31:0] c;
        logic [31:0] cnt;
    } exp_t;

    exp_t       sb[$];
    logic [5:0] q[4][$];
    logic [5:0] lane[4];
    logic [3:0] rd_prev;
    logic [7:0] exp_cnt[4];
    int         last_g;
    bit         refill_en;
    int         cyc = 0;
    bit         issued_log[int];
    int         n_vec = 0;
    int         n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference grant: first non-empty queue after the last grant, wrapping modulo 4.
    function automatic int pick();
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (last_g + k) % 4;
            if (q[i].size() > 0) return i;
        end
        return -1;
    endfunction

    // One clock cycle: upstream FIFOs react to last cycle's pops, inputs are driven, pop checked.
    task automatic step(input bit r, input bit p, input logic [3:0] af);
        int         g;
        logic [3:0] exp_rd;
        logic [5:0] w;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (rd_prev[i] && q[i].size() > 0) lane[i] = q[i].pop_front();
            else                               lane[i] = 6'($urandom);
            if (refill_en && q[i].size() < 8 && $urandom_range(0, 2) == 0)
                q[i].push_back(6'($urandom));
        end
        if (!r && RESET_L) begin
            sb.delete();
            last_g = 3;
            for (int d = 0; d < 4; d++) exp_cnt[d] = 8'd0;
        end
        RESET_L     = r;
        pause       = p;
        almost_full = af;
        for (int i = 0; i < 4; i++) begin
            fifo_empty[i]      = (q[i].size() == 0);
            data_in[6*i +: 6]  = lane[i];
        end
        #1;
        if (!r) begin
            chk("rst_push", {28'd0, push}, 32'd0);
            chk("rst_data_out", {26'd0, data_out}, 32'd0);
            chk("rst_active", {31'd0, active}, 32'd0);
            chk("rst_cnt_dest", cnt_dest, 32'd0);
        end
        g = -1;
        if (r && !p && af == 4'd0) g = pick();
        exp_rd = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        chk("fifo_rd", {28'd0, fifo_rd}, {28'd0, exp_rd});
        if (g >= 0) begin
            w = q[g][0];
            exp_cnt[w[5:4]] = exp_cnt[w[5:4]] + 8'd1;
            sb.push_back('{w, 32'(cyc + 2), {exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0]}});
            last_g = g;
            issued_log[cyc] = 1'b1;
        end
        rd_prev = fifo_rd;
    endtask

    // Monitor: every push must match the oldest expected word, its cycle and the counters.
    initial begin
        exp_t       e;
        bit         due;
        logic [3:0] oh;
        forever begin
            @(posedge clk);
            #1;
            due = (sb.size() > 0) && (sb[0].c == 32'(cyc));
            chk("active", {31'd0, active},
                {31'd0, RESET_L && (issued_log.exists(cyc - 1) || due)});
            if (push !== 4'b0000) begin
                if (sb.size() == 0) begin
                    chk("push_unexpected", {28'd0, push}, 32'd0);
                end else begin
                    e  = sb.pop_front();
                    oh = 4'b0001 << e.w[5:4];
                    chk("push", {28'd0, push}, {28'd0, oh});
                    chk("data_out", {26'd0, data_out}, {26'd0, e.w});
                    chk("push_cycle", 32'(cyc), e.c);
                    chk("cnt_dest", cnt_dest, e.cnt);
                end
            end else if (due) begin
                e  = sb.pop_front();
                oh = 4'b0001 << e.w[5:4];
                chk("push_missing", {28'd0, push}, {28'd0, oh});
            end
        end
    end

    initial begin
        int sent;
        int guard;
        RESET_L     = 1'b0;
        pause       = 1'b0;
        almost_full = 4'd0;
        fifo_empty  = 4'hF;
        data_in     = 24'd0;
        rd_prev     = 4'd0;
        last_g      = 3;
        refill_en   = 1'b0;
        for (int d = 0; d < 4; d++) exp_cnt[d] = 8'd0;

        repeat (3) step(1'b0, 1'b0, 4'd0);

        // Single word from FIFO 2 to destination 3.
        q[2].push_back(6'h35);
        repeat (5) step(1'b1, 1'b0, 4'd0);
        chk("single_cnt", cnt_dest, 32'h0100_0000);

        // 256 words to destination 0 wrap its counter back to its previous value.
        sent  = 0;
        guard = 0;
        while (sent < 256 && guard < 2000) begin
            for (int i = 0; i < 4; i++)
                while (q[i].size() < 8 && sent < 256) begin
                    q[i].push_back({2'b00, 4'($urandom)});
                    sent++;
                end
            step(1'b1, 1'b0, 4'd0);
            guard++;
        end
        chk("wrap_budget", {31'd0, guard < 2000}, 32'd1);
        repeat (40) step(1'b1, 1'b0, 4'd0);
        chk("wrap_cnt", cnt_dest, 32'h0100_0000);

        // Round-robin across four queues of three words.
        for (int i = 0; i < 4; i++) repeat (3) q[i].push_back(6'($urandom));
        repeat (16) step(1'b1, 1'b0, 4'd0);

        // Same-FIFO back-to-back pops with a pause in the middle.
        repeat (8) q[0].push_back(6'($urandom));
        repeat (4) step(1'b1, 1'b0, 4'd0);
        repeat (3) step(1'b1, 1'b1, 4'd0);
        repeat (9) step(1'b1, 1'b0, 4'd0);

        // Backpressure from destination 1.
        for (int i = 0; i < 4; i++) repeat (3) q[i].push_back(6'($urandom));
        repeat (3) step(1'b1, 1'b0, 4'd0);
        repeat (4) step(1'b1, 1'b0, 4'b0010);
        repeat (16) step(1'b1, 1'b0, 4'd0);

        // Reset one cycle after a pop: in-flight word dropped, first grant then goes to FIFO 0.
        repeat (3) q[1].push_back(6'($urandom));
        repeat (2) q[3].push_back(6'($urandom));
        step(1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 4'd0);
        repeat (2) q[0].push_back(6'($urandom));
        step(1'b1, 1'b0, 4'd0);
        chk("first_after_reset", {28'd0, fifo_rd}, 32'd1);
        repeat (12) step(1'b1, 1'b0, 4'd0);

        // Randomised traffic with sporadic pause and almost-full.
        refill_en = 1'b1;
        repeat (1500)
            step(1'b1, $urandom_range(0, 7) == 0,
                 ($urandom_range(0, 9) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'd0);
        refill_en = 1'b0;
        repeat (45) step(1'b1, 1'b0, 4'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
